// File: rtl/pc_region_profiler.sv
// Bus-attached PC window profiler: counts calls, total and last-call cycles per address window.
// Optional per-region MAX register is built when PC_PROFILER_MAX_EN is defined.
module pc_region_profiler #(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned CntWidth   = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  function automatic logic [CntWidth-1:0] f_sat_add(input logic [CntWidth-1:0] a,
                                                    input logic [CntWidth-1:0] b);
    logic [CntWidth:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CntWidth] ? '1 : s[CntWidth-1:0];
  endfunction

  logic        w_wr;
  logic        w_is_region;
  logic        w_is_ctrl;
  logic        w_ctrl_wr;
  logic        w_clr;
  logic [3:0]  w_ridx;
  logic [2:0]  w_rsel;
  logic [31:0] w_rd_data;
  logic        w_unused_addr;

  logic        r_en;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic [31:0]         w_start [NumRegions];
  logic [31:0]         w_end   [NumRegions];
  logic [CntWidth-1:0] w_calls [NumRegions];
  logic [CntWidth-1:0] w_total [NumRegions];
  logic [CntWidth-1:0] w_last  [NumRegions];
  logic [CntWidth-1:0] w_max   [NumRegions];

  // Regions occupy 0x000-0x1FF (addr[9]=0); CTRL sits at word 0x80 (byte 0x200).
  assign w_wr          = req_i & we_i;
  assign w_is_region   = ~addr_i[9];
  assign w_ridx        = addr_i[8:5];
  assign w_rsel        = addr_i[4:2];
  assign w_is_ctrl     = (addr_i[9:2] == 8'h80);
  assign w_ctrl_wr     = w_wr & w_is_ctrl & be_i[0];
  assign w_clr         = w_ctrl_wr & wdata_i[1];
  assign w_unused_addr = ^{addr_i[31:10], addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en <= wdata_i[0];
    end
  end

  for (genvar gi = 0; gi < NumRegions; gi++) begin : g_region
    logic                w_sel;
    logic                w_start_hit;
    logic                w_end_hit;
    logic                w_commit;
    logic [CntWidth-1:0] w_dur_inc;
    logic [CntWidth-1:0] w_new_last;

    logic [31:0]         r_start;
    logic [31:0]         r_end;
    logic [CntWidth-1:0] r_calls;
    logic [CntWidth-1:0] r_total;
    logic [CntWidth-1:0] r_last;
    logic [CntWidth-1:0] r_dur;
    state_t              r_state;

    assign w_sel       = w_wr & w_is_region & (w_ridx == 4'(gi));
    assign w_start_hit = r_en & pc_valid_i & (pc_i == r_start);
    assign w_end_hit   = r_en & pc_valid_i & (pc_i == r_end);
    assign w_dur_inc   = f_sat_add(r_dur, CntOne);
    // A zero-length window (START==END) completes in the same cycle it starts.
    assign w_commit    = (r_state == ST_ACTIVE) ? w_end_hit
                                                : (w_start_hit && (r_start == r_end));
    assign w_new_last  = (r_state == ST_ACTIVE) ? w_dur_inc : CntOne;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_start <= '0;
        r_end   <= '0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (w_sel && (w_rsel == 3'd0) && be_i[b]) r_start[8*b +: 8] <= wdata_i[8*b +: 8];
          if (w_sel && (w_rsel == 3'd1) && be_i[b]) r_end[8*b +: 8]   <= wdata_i[8*b +: 8];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= ST_IDLE;
        r_calls <= '0;
        r_total <= '0;
        r_last  <= '0;
        r_dur   <= '0;
      end else if (w_clr) begin
        r_state <= ST_IDLE;
        r_calls <= '0;
        r_total <= '0;
        r_last  <= '0;
        r_dur   <= '0;
      end else if (!r_en) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_hit) begin
              r_calls <= f_sat_add(r_calls, CntOne);
              r_dur   <= CntOne;
              if (!w_commit) r_state <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (w_end_hit) begin
              r_state <= ST_IDLE;
            end else begin
              r_dur <= w_dur_inc;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_commit) begin
          r_last  <= w_new_last;
          r_total <= f_sat_add(r_total, w_new_last);
        end
      end
    end

`ifdef PC_PROFILER_MAX_EN
    logic [CntWidth-1:0] r_max;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_max <= '0;
      end else if (w_clr) begin
        r_max <= '0;
      end else if (w_commit && (w_new_last > r_max)) begin
        r_max <= w_new_last;
      end
    end

    assign w_max[gi] = r_max;
`else
    assign w_max[gi] = '0;
`endif

    assign w_start[gi] = r_start;
    assign w_end[gi]   = r_end;
    assign w_calls[gi] = r_calls;
    assign w_total[gi] = r_total;
    assign w_last[gi]  = r_last;
  end

  always_comb begin
    w_rd_data = '0;
    if (w_is_ctrl) begin
      w_rd_data = {31'b0, r_en};
    end else if (w_is_region) begin
      for (int k = 0; k < NumRegions; k++) begin
        if (w_ridx == 4'(k)) begin
          case (w_rsel)
            3'd0:    w_rd_data = w_start[k];
            3'd1:    w_rd_data = w_end[k];
            3'd2:    w_rd_data = 32'(w_calls[k]);
            3'd3:    w_rd_data = 32'(w_total[k]);
            3'd4:    w_rd_data = 32'(w_last[k]);
            3'd5:    w_rd_data = 32'(w_max[k]);
            default: w_rd_data = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= (req_i && !we_i) ? w_rd_data : '0;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;

endmodule
